// File: rtl/ctrl_pkg.sv
// Shared definitions for the exposure controller: state encoding, exposure limits and
// the clamp applied to the requested exposure time.
package ctrl_pkg;

  localparam int unsigned EX_W           = 5;
  localparam int unsigned EX_MIN_DEFAULT = 2;
  localparam int unsigned EX_MAX_DEFAULT = 30;
  localparam int unsigned READOUT_LEN    = 7;

  typedef logic [EX_W-1:0] ex_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPOSE  = 2'd1,
    READOUT = 2'd2
  } state_e;

  // Saturate a requested exposure length into [lo, hi].
  function automatic ex_t clamp_ex(ex_t v, ex_t lo, ex_t hi);
    ex_t r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/ctrl_ex_counter.sv
// Loadable down-counter shared by the EXPOSE and READOUT phases. The next value is exported
// so the owner can register outputs decoded from the counter without an extra cycle of lag.
module ctrl_ex_counter
  import ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [EX_W-1:0] load_val_i,
  input  logic            dec_i,
  output logic [EX_W-1:0] count_d_o,
  output logic            tc_o
);

  logic [EX_W-1:0] count_q, count_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - EX_W'(1);
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_d_o = count_d;
  assign tc_o      = (count_q == '0);

endmodule

// File: rtl/ctrl_exposure_fsm.sv
// Pixel exposure / readout sequencer. One frame is N exposure cycles (N = clamped EX_time,
// latched at start) followed by a fixed 7-cycle two-row readout, then at least one IDLE cycle.
// All outputs are flops decoded from next state and next counter value.
module ctrl_exposure_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned EX_MIN = EX_MIN_DEFAULT,
  parameter int unsigned EX_MAX = EX_MAX_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Init,
  input  logic [EX_W-1:0] EX_time,
  output logic            Erase,
  output logic            Expose,
  output logic            NRE_1,
  output logic            NRE_2,
  output logic            ADC,
  output logic            Busy,
  output logic            Frame_done
);

  localparam ex_t ExMin     = ex_t'(EX_MIN);
  localparam ex_t ExMax     = ex_t'(EX_MAX);
  localparam ex_t RoLoadVal = ex_t'(READOUT_LEN - 1);

  state_e state_q, state_d;

  logic            cnt_load;
  logic [EX_W-1:0] cnt_load_val;
  logic            cnt_dec;
  logic [EX_W-1:0] cnt_d;
  logic            cnt_tc;

  logic erase_d, expose_d, nre_1_d, nre_2_d, adc_d, busy_d, frame_done_d;

  // Counter holds remaining cycles minus one; terminal count marks the last cycle of a phase.
  ctrl_ex_counter u_ex_counter (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .count_d_o  (cnt_d),
    .tc_o       (cnt_tc)
  );

  // Next-state and counter control.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Init) begin
          state_d      = EXPOSE;
          cnt_load     = 1'b1;
          cnt_load_val = clamp_ex(EX_time, ExMin, ExMax) - ex_t'(1);
        end
      end
      EXPOSE: begin
        if (cnt_tc) begin
          state_d      = READOUT;
          cnt_load     = 1'b1;
          cnt_load_val = RoLoadVal;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      READOUT: begin
        if (cnt_tc) state_d = IDLE;
        else        cnt_dec = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        cnt_load = 1'b1;
      end
    endcase
  end

  // Output decode for the coming cycle. In READOUT the count runs 6..0 for R0..R6.
  always_comb begin
    erase_d      = 1'b1;
    expose_d     = 1'b0;
    nre_1_d      = 1'b1;
    nre_2_d      = 1'b1;
    adc_d        = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = (state_q == READOUT) && cnt_tc;
    case (state_d)
      EXPOSE: begin
        erase_d  = 1'b0;
        expose_d = 1'b1;
        busy_d   = 1'b1;
      end
      READOUT: begin
        erase_d = 1'b0;
        busy_d  = 1'b1;
        nre_1_d = !(cnt_d >= ex_t'(4));
        nre_2_d = !(cnt_d <= ex_t'(2));
        adc_d   = (cnt_d == ex_t'(5)) || (cnt_d == ex_t'(1));
      end
      default: ;
    endcase
  end

  // State and output registers; reset forces IDLE outputs and suppresses Frame_done.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      Erase      <= 1'b1;
      Expose     <= 1'b0;
      NRE_1      <= 1'b1;
      NRE_2      <= 1'b1;
      ADC        <= 1'b0;
      Busy       <= 1'b0;
      Frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      Erase      <= erase_d;
      Expose     <= expose_d;
      NRE_1      <= nre_1_d;
      NRE_2      <= nre_2_d;
      ADC        <= adc_d;
      Busy       <= busy_d;
      Frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_ctrl_exposure_fsm.sv
// Bench for ctrl_exposure_fsm: a cycle model pushes expected outputs into a queue as each
// input set is driven; they are popped and compared one cycle later. A vector table covers
// exposure clamping; hand sequences cover mid-frame EX_time changes, resets and held Init.
module tb_ctrl_exposure_fsm;

  logic       Clk = 1'b0;
  logic       Reset, Init;
  logic [4:0] EX_time;
  logic       Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_done;

  always #5 Clk = ~Clk;

  ctrl_exposure_fsm #(
    .EX_MIN (2),
    .EX_MAX (30)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Init       (Init),
    .EX_time    (EX_time),
    .Erase      (Erase),
    .Expose     (Expose),
    .NRE_1      (NRE_1),
    .NRE_2      (NRE_2),
    .ADC        (ADC),
    .Busy       (Busy),
    .Frame_done (Frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];
  bit checking = 1'b0;

  int exp_len = 0;
  int fd_seen = 0;
  int cyc     = 0;

  // Reference model: phase 0 idle, 1 expose, 2 readout; counts upward.
  int   m_phase = 0;
  int   m_cnt   = 0;
  int   m_n     = 0;
  int   m_ridx  = 0;
  logic m_done  = 1'b0;

  function automatic int tb_clamp(input logic [4:0] v);
    if (v < 5'd2)  return 2;
    if (v > 5'd30) return 30;
    return int'(v);
  endfunction

  task automatic model_step(input logic r, input logic i, input logic [4:0] e);
    if (!r) begin
      m_phase = 0;
      m_done  = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_done = 1'b0;
          if (i) begin
            m_n     = tb_clamp(e);
            m_cnt   = 1;
            m_phase = 1;
          end
        end
        1: begin
          if (m_cnt == m_n) begin
            m_phase = 2;
            m_ridx  = 0;
          end else begin
            m_cnt++;
          end
        end
        default: begin
          if (m_ridx == 6) begin
            m_phase = 0;
            m_done  = 1'b1;
          end else begin
            m_ridx++;
          end
        end
      endcase
    end
  endtask

  // {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_done}
  function automatic logic [6:0] model_out();
    case (m_phase)
      0:       return {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, m_done};
      1:       return 7'b0111010;
      default: return {1'b0, 1'b0, (m_ridx > 2), (m_ridx < 4),
                       (m_ridx == 1) || (m_ridx == 5), 1'b1, 1'b0};
    endcase
  endfunction

  task automatic tick(input logic r, input logic i, input logic [4:0] e);
    logic [6:0] want, got;
    @(negedge Clk);
    Reset   = r;
    Init    = i;
    EX_time = e;
    model_step(r, i, e);
    exp_q.push_back(model_out());
    @(posedge Clk);
    #1;
    cyc++;
    got  = {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_done};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL outputs cyc=%0d {Erase,Expose,NRE_1,NRE_2,ADC,Busy,Frame_done} got %b want %b",
               cyc, got, want);
    end
    if (Expose === 1'b1) exp_len++;
    if (Frame_done === 1'b1) fd_seen++;
  endtask

  // One frame from IDLE: Init pulse, EX_time switches to ex1 from exposure cycle sw onward.
  task automatic frame(input logic [4:0] ex0, input logic [4:0] ex1, input int sw,
                       input int want, input string name);
    bit done;
    done    = 1'b0;
    exp_len = 0;
    fd_seen = 0;
    tick(1'b1, 1'b1, ex0);
    for (int c = 1; c <= 60 && !done; c++) begin
      tick(1'b1, 1'b0, (c >= sw) ? ex1 : ex0);
      if (fd_seen != 0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s frame_done got none within 60 cycles want 1 pulse", name);
    end
    n_checks++;
    if (exp_len != want) begin
      n_fail++;
      $display("FAIL %s expose_len got %0d want %0d", name, exp_len, want);
    end
  endtask

  // Readout rows are mutually exclusive; ADC strobes only inside a row-read window.
  always @(negedge Clk) begin
    if (checking) begin
      n_checks++;
      if ((NRE_1 === 1'b0) && (NRE_2 === 1'b0)) begin
        n_fail++;
        $display("FAIL nre_overlap NRE_1=%b NRE_2=%b want not both 0", NRE_1, NRE_2);
      end else if ((ADC === 1'b1) && (NRE_1 !== 1'b0) && (NRE_2 !== 1'b0)) begin
        n_fail++;
        $display("FAIL adc_window ADC=%b with NRE_1=%b NRE_2=%b want ADC only in R1/R5",
                 ADC, NRE_1, NRE_2);
      end
    end
  end

  typedef struct {
    logic [4:0] ex;
    int         len;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int last_fd;
    int frames;

    vecs[0] = '{ex: 5'd10, len: 10};
    vecs[1] = '{ex: 5'd0,  len: 2};
    vecs[2] = '{ex: 5'd31, len: 30};
    vecs[3] = '{ex: 5'd1,  len: 2};
    vecs[4] = '{ex: 5'd2,  len: 2};
    vecs[5] = '{ex: 5'd3,  len: 3};
    vecs[6] = '{ex: 5'd30, len: 30};
    vecs[7] = '{ex: 5'd17, len: 17};

    Reset   = 1'b0;
    Init    = 1'b0;
    EX_time = 5'd0;

    // Reset for 2 cycles, plus Init asserted during reset must not start a frame.
    tick(1'b0, 1'b0, 5'd0);
    tick(1'b0, 1'b1, 5'd10);
    checking = 1'b1;
    tick(1'b1, 1'b0, 5'd10);

    // Clamp table.
    for (int k = 0; k < 8; k++) begin
      frame(vecs[k].ex, vecs[k].ex, 99, vecs[k].len, $sformatf("vec%0d_ex%0d", k, vecs[k].ex));
    end

    // EX_time changes during exposure cycle 4: current frame unaffected, next uses 3.
    frame(5'd10, 5'd3, 4, 10, "ex_change_mid");
    frame(5'd3, 5'd3, 99, 3, "ex_change_next");

    // Reset during EXPOSE cycle 5.
    tick(1'b1, 1'b1, 5'd10);
    for (int c = 1; c <= 4; c++) tick(1'b1, 1'b0, 5'd10);
    fd_seen = 0;
    tick(1'b0, 1'b0, 5'd10);
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b0, 5'd10);
    n_checks++;
    if (fd_seen != 0) begin
      n_fail++;
      $display("FAIL rst_in_expose frame_done pulses got %0d want 0", fd_seen);
    end

    // Reset during R4 (EX_time=2: E1 E2 R0 R1 R2 R3 then R4).
    tick(1'b1, 1'b1, 5'd2);
    for (int c = 1; c <= 6; c++) tick(1'b1, 1'b0, 5'd2);
    fd_seen = 0;
    tick(1'b0, 1'b0, 5'd2);
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b0, 5'd2);
    n_checks++;
    if (fd_seen != 0) begin
      n_fail++;
      $display("FAIL rst_in_r4 frame_done pulses got %0d want 0", fd_seen);
    end

    // Init held high with EX_time=2: back-to-back frames every 10 cycles.
    last_fd = -1;
    frames  = 0;
    for (int c = 0; c < 45; c++) begin
      tick(1'b1, 1'b1, 5'd2);
      if (Frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          n_checks++;
          if (cyc - last_fd != 10) begin
            n_fail++;
            $display("FAIL frame_period got %0d want 10", cyc - last_fd);
          end
        end
        last_fd = cyc;
        frames++;
      end
    end
    n_checks++;
    if (frames < 4) begin
      n_fail++;
      $display("FAIL held_init frames got %0d want >= 4", frames);
    end
    for (int c = 0; c < 12; c++) tick(1'b1, 1'b0, 5'd2);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
